list_sum_datapath: RTL and testbench

//   Datapath half of the linked-list summing engine; the list-sum controller FSM drives it.

---
 rtl/list_sum_pkg.sv | 15 +
 rtl/list_node_ram.sv | 30 +++
 rtl/list_sum_datapath.sv | 123 ++++++++++++
 tb/tb_list_sum_datapath.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/list_sum_pkg.sv
// Shared defaults, pointer constants and types for the linked-list summing datapath.
package list_sum_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 4;

    // Address 0 is the dummy node; a link of 0 terminates the list.
    localparam int unsigned NULL_PTR  = 0;
    // mem[HEAD_ADDR] holds the pointer to the first node.
    localparam int unsigned HEAD_ADDR = 1;

    typedef logic [DEF_DATA_W-1:0] data_t;
    typedef logic [DEF_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/list_node_ram.sv
// Node storage: one synchronous write port for the host, one asynchronous read port
// for the datapath. Contents are not reset.
module list_node_ram
    import list_sum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    // Host write; a read of the same address in this cycle still sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/list_sum_datapath.sv
// Datapath half of the linked-list summing engine: node RAM, SUM and NEXT registers,
// DONE edge detector and result latch. All sequencing comes from the external FSM.
// Optional feature: define LIST_SUM_OVF_EN to add the sticky sum_ovf output.
module list_sum_datapath
    import list_sum_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              LD_SUM,
    input  logic              LD_NEXT,
    input  logic              SUM_SEL,
    input  logic              NEXT_SEL,
    input  logic              A_SEL,
    input  logic              DONE,
    output logic              next_zero,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_waddr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] sum,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
`ifdef LIST_SUM_OVF_EN
    ,
    output logic              sum_ovf
`endif
);

    logic [ADDR_W-1:0] next_q, next_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic [DATA_W-1:0] result_q;
    logic              result_valid_q;
    logic              done_q;
    logic              done_rise;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] sum_add;

    // A_SEL picks the link field (p+1) or the value field (p); the increment wraps.
    assign raddr = A_SEL ? next_q + ADDR_W'(1) : next_q;

    list_node_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (raddr),
        .rdata (rdata)
    );

`ifdef LIST_SUM_OVF_EN
    logic sum_carry;
    logic ovf_q, ovf_d;

    assign {sum_carry, sum_add} = {1'b0, sum_q} + {1'b0, rdata};

    // Overflow flag: sticky across accumulating loads, dropped by a clearing load.
    always_comb begin
        ovf_d = ovf_q;
        if (LD_SUM) begin
            ovf_d = SUM_SEL ? (ovf_q | sum_carry) : 1'b0;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign sum_ovf = ovf_q;
`else
    assign sum_add = sum_q + rdata;
`endif

    // Next-state for SUM and NEXT; both loads in one cycle share the same rdata.
    always_comb begin
        sum_d  = sum_q;
        next_d = next_q;
        if (LD_SUM) begin
            sum_d = SUM_SEL ? sum_add : '0;
        end
        if (LD_NEXT) begin
            next_d = NEXT_SEL ? rdata[ADDR_W-1:0] : '0;
        end
    end

    assign done_rise = DONE & ~done_q;

    // Datapath registers; reset overrides every load and capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q          <= '0;
            next_q         <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            sum_q          <= sum_d;
            next_q         <= next_d;
            done_q         <= DONE;
            result_valid_q <= done_rise;
            // Captures the pre-update SUM even when LD_SUM fires in the same cycle.
            if (done_rise) begin
                result_q <= sum_q;
            end
        end
    end

    assign next_zero    = (next_q == ADDR_W'(NULL_PTR));
    assign sum          = sum_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_list_sum_datapath.sv
// Self-checking bench for list_sum_datapath. The bench plays the controller FSM and
// compares against a list-walking reference model. Build with LIST_SUM_OVF_EN to run
// the 8-bit overflow scenario as well.
module tb_list_sum_datapath;
    import list_sum_pkg::*;

`ifdef LIST_SUM_OVF_EN
    localparam int unsigned W = 8;
`else
    localparam int unsigned W = 32;
`endif
    localparam int unsigned A = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          LD_SUM = 1'b0, LD_NEXT = 1'b0, SUM_SEL = 1'b0, NEXT_SEL = 1'b0;
    logic          A_SEL = 1'b0, DONE = 1'b0;
    logic          next_zero;
    logic          mem_we = 1'b0;
    logic [A-1:0]  mem_waddr = '0;
    logic [W-1:0]  mem_wdata = '0;
    logic [W-1:0]  sum, result;
    logic          result_valid;
`ifdef LIST_SUM_OVF_EN
    logic          sum_ovf;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference memory image, mirrors every host write.
    logic [W-1:0] mm [16];

    list_sum_datapath #(
        .DATA_W (W),
        .ADDR_W (A)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .LD_SUM       (LD_SUM),
        .LD_NEXT      (LD_NEXT),
        .SUM_SEL      (SUM_SEL),
        .NEXT_SEL     (NEXT_SEL),
        .A_SEL        (A_SEL),
        .DONE         (DONE),
        .next_zero    (next_zero),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .sum          (sum),
        .result       (result),
        .result_valid (result_valid)
`ifdef LIST_SUM_OVF_EN
        ,
        .sum_ovf      (sum_ovf)
`endif
    );

    always #5 clk = ~clk;

    // One controller cycle; outputs are sampled 1ns after the edge.
    task automatic drive(input bit ld_sum, input bit sum_sel, input bit ld_next,
                         input bit next_sel, input bit a_sel, input bit done);
        LD_SUM = ld_sum; SUM_SEL = sum_sel; LD_NEXT = ld_next;
        NEXT_SEL = next_sel; A_SEL = a_sel; DONE = done;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d);
        LD_SUM = 0; LD_NEXT = 0; SUM_SEL = 0; NEXT_SEL = 0; A_SEL = 0; DONE = 0;
        mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        mm[a] = d;
    endtask

    task automatic load_example();
        wr(4'd1, W'(4)); wr(4'd4, W'(10)); wr(4'd5, W'(8)); wr(4'd8, W'(7)); wr(4'd9, W'(0));
    endtask

    // Full traversal from the head; model walks mm with plain arithmetic.
    task automatic traverse(input string tag, output logic [W-1:0] esum);
        logic [A-1:0] p, q;
        logic [W:0]   wide;
        logic         eovf;
        int           n;
        drive(1, 0, 1, 0, 0, 0);
        vectors++;
        if (sum !== '0 || next_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL %s clear: sum=%0d nz=%b, want sum=0 nz=1", tag, sum, next_zero);
        end
        drive(0, 0, 1, 1, 1, 0);
        p = mm[HEAD_ADDR][A-1:0];
        vectors++;
        if (next_zero !== (p == 0)) begin
            miscompares++;
            $display("FAIL %s head: nz=%b want %b", tag, next_zero, (p == 0));
        end
        esum = '0;
        eovf = 1'b0;
        n = 0;
        while (p != 0 && n < 8) begin
            drive(1, 1, 0, 0, 0, 0);
            wide = {1'b0, esum} + {1'b0, mm[p]};
            esum = wide[W-1:0];
            if (wide[W]) eovf = 1'b1;
            vectors++;
            if (sum !== esum) begin
                miscompares++;
                $display("FAIL %s value node %0d: sum=%0d want %0d", tag, p, sum, esum);
            end
            drive(0, 0, 1, 1, 1, 0);
            q = p + 4'd1;
            p = mm[q][A-1:0];
            vectors++;
            if (next_zero !== (p == 0)) begin
                miscompares++;
                $display("FAIL %s link: nz=%b want %b", tag, next_zero, (p == 0));
            end
            n++;
        end
`ifdef LIST_SUM_OVF_EN
        vectors++;
        if (sum_ovf !== eovf) begin
            miscompares++;
            $display("FAIL %s ovf: sum_ovf=%b want %b", tag, sum_ovf, eovf);
        end
`endif
    endtask

    // DONE raised and held for three cycles: exactly one capture pulse.
    task automatic done_check(input string tag, input logic [W-1:0] exp);
        drive(0, 0, 0, 0, 0, 1);
        vectors++;
        if (result_valid !== 1'b1 || result !== exp) begin
            miscompares++;
            $display("FAIL %s done: valid=%b result=%0d want valid=1 result=%0d",
                     tag, result_valid, result, exp);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0, 1);
            vectors++;
            if (result_valid !== 1'b0 || result !== exp) begin
                miscompares++;
                $display("FAIL %s held %0d: valid=%b result=%0d want valid=0 result=%0d",
                         tag, i, result_valid, result, exp);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, 1, 1, 1, 0, 1);
        drive(1, 1, 1, 1, 0, 1);
        rst = 1'b0;
        vectors++;
        if (sum !== '0 || result !== '0 || result_valid !== 1'b0 || next_zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: sum=%0d result=%0d valid=%b nz=%b, want 0 0 0 1",
                     sum, result, result_valid, next_zero);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_example();
        logic [W-1:0] s;
        load_example();
        traverse("example", s);
        vectors++;
        if (sum !== W'(17) || s !== W'(17)) begin
            miscompares++;
            $display("FAIL example total: sum=%0d want 17", sum);
        end
        done_check("example", W'(17));
    endtask

    task automatic test_empty();
        logic [W-1:0] s;
        wr(4'd1, W'(0));
        traverse("empty", s);
        done_check("empty", W'(0));
    endtask

    task automatic test_reset_mid();
        load_example();
        drive(1, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        vectors++;
        if (sum !== W'(10) || next_zero !== 1'b0 || result !== W'(10)) begin
            miscompares++;
            $display("FAIL midlist setup: sum=%0d nz=%b result=%0d want 10 0 10",
                     sum, next_zero, result);
        end
        rst = 1'b1;
        drive(1, 1, 1, 1, 1, 1);
        rst = 1'b0;
        vectors++;
        if (sum !== '0 || next_zero !== 1'b1 || result !== '0 || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midlist reset: sum=%0d nz=%b result=%0d valid=%b want 0 1 0 0",
                     sum, next_zero, result, result_valid);
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // SEL inputs without LD must not disturb either register.
    task automatic test_hold();
        load_example();
        drive(1, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, $urandom_range(1, 0), 0, $urandom_range(1, 0), $urandom_range(1, 0), 0);
            vectors++;
            if (sum !== W'(10) || next_zero !== 1'b0) begin
                miscompares++;
                $display("FAIL hold %0d: sum=%0d nz=%b want 10 0", i, sum, next_zero);
            end
        end
    endtask

    // Both loads from the dummy node in one cycle, then DONE coinciding with LD_SUM.
    task automatic test_both_ld_and_done();
        logic [W-1:0] v, v2, pre;
        v = W'($urandom);
        v[A-1:0] = 4'd6;
        wr(4'd0, v);
        drive(1, 0, 1, 0, 0, 0);
        drive(1, 1, 1, 1, 0, 0);
        vectors++;
        if (sum !== v || next_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL both_ld: sum=%0d nz=%b want %0d 0", sum, next_zero, v);
        end
        v2 = W'($urandom);
        wr(4'd6, v2);
        pre = sum;
        drive(1, 1, 0, 0, 0, 1);
        vectors++;
        if (result !== pre || result_valid !== 1'b1 || sum !== W'(pre + v2)) begin
            miscompares++;
            $display("FAIL done_with_ld: result=%0d valid=%b sum=%0d want %0d 1 %0d",
                     result, result_valid, sum, pre, W'(pre + v2));
        end
        drive(0, 0, 0, 0, 0, 0);
    endtask

    // Host write and datapath read of the same word in one cycle: old data is summed.
    task automatic test_rw_collision();
        logic [W-1:0] oldv, newv;
        oldv = W'($urandom);
        newv = W'($urandom);
        wr(4'd0, oldv);
        drive(1, 0, 1, 0, 0, 0);
        mem_we = 1'b1; mem_waddr = 4'd0; mem_wdata = newv;
        drive(1, 1, 0, 0, 0, 0);
        mem_we = 1'b0;
        mm[0] = newv;
        vectors++;
        if (sum !== oldv) begin
            miscompares++;
            $display("FAIL rw_collision: sum=%0d want old %0d", sum, oldv);
        end
        drive(1, 1, 0, 0, 0, 0);
        vectors++;
        if (sum !== W'(oldv + newv)) begin
            miscompares++;
            $display("FAIL rw_after: sum=%0d want %0d", sum, W'(oldv + newv));
        end
    endtask

    // Random lists over the even slots 2..14, random values and link upper bits.
    task automatic test_random_lists();
        logic [A-1:0] slots [7];
        logic [A-1:0] t;
        logic [W-1:0] lnk, s;
        int           len, j;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 7; i++) slots[i] = 4'(2 * (i + 1));
            for (int i = 6; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = slots[i]; slots[i] = slots[j]; slots[j] = t;
            end
            len = $urandom_range(7, 0);
            lnk = W'($urandom);
            lnk[A-1:0] = (len > 0) ? slots[0] : 4'd0;
            wr(4'(HEAD_ADDR), lnk);
            for (int i = 0; i < len; i++) begin
                wr(slots[i], W'($urandom));
                lnk = W'($urandom);
                lnk[A-1:0] = (i + 1 < len) ? slots[i + 1] : 4'd0;
                wr(slots[i] + 4'd1, lnk);
            end
            traverse($sformatf("rand%0d", it), s);
            done_check($sformatf("rand%0d", it), s);
        end
    endtask

`ifdef LIST_SUM_OVF_EN
    task automatic test_ovf();
        logic [W-1:0] s;
        wr(4'd1, W'(2)); wr(4'd2, W'(200)); wr(4'd3, W'(6)); wr(4'd6, W'(100)); wr(4'd7, W'(0));
        traverse("ovf", s);
        vectors++;
        if (sum !== W'(44) || sum_ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf total: sum=%0d ovf=%b want 44 1", sum, sum_ovf);
        end
        drive(1, 0, 0, 0, 0, 0);
        vectors++;
        if (sum_ovf !== 1'b0 || sum !== '0) begin
            miscompares++;
            $display("FAIL ovf clear: ovf=%b sum=%0d want 0 0", sum_ovf, sum);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mm[i] = '0;
        for (int i = 0; i < 16; i++) wr(4'(i), '0);
        test_reset();
        test_example();
        test_empty();
        test_reset_mid();
        test_hold();
        test_both_ld_and_done();
        test_rw_collision();
        test_random_lists();
`ifdef LIST_SUM_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
